// File: rtl/fetch_stage_axi.sv
// Instruction fetch stage: owns the PC and issues one AXI4-Lite read at a
// time, handing each returned word to decode over a valid/ready handshake.
// Redirects either retarget the next fetch directly or, when a read is in
// flight, mark that read to be discarded and fetch the target afterwards.
module fetch_stage_axi #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [2:0]  ARPROT_VAL = 3'b100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_err,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pending_pc, pending_pc_n;
  logic        kill, kill_n;

  logic        arvalid_n;
  logic [31:0] araddr_n;
  logic        rready_n;
  logic        instr_valid_n;
  logic [31:0] instruction_n;
  logic [31:0] instr_pc_n;
  logic        instr_err_n;

  // Redirect target with the byte-offset bits forced to zero.
  logic [31:0] target;
  assign target = redirect_pc & 32'hFFFF_FFFC;

  assign m_arprot = ARPROT_VAL;

  // State, PC and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_START;
      pc          <= RESET_PC;
      pending_pc  <= RESET_PC;
      kill        <= 1'b0;
      m_arvalid   <= 1'b0;
      m_araddr    <= RESET_PC;
      m_rready    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      instr_err   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pending_pc  <= pending_pc_n;
      kill        <= kill_n;
      m_arvalid   <= arvalid_n;
      m_araddr    <= araddr_n;
      m_rready    <= rready_n;
      instr_valid <= instr_valid_n;
      instruction <= instruction_n;
      instr_pc    <= instr_pc_n;
      instr_err   <= instr_err_n;
    end
  end

  // Next-state and next-output computation; outputs are registered so every
  // transition into ADDR also loads the address it will present.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pending_pc_n  = pending_pc;
    kill_n        = kill;
    arvalid_n     = m_arvalid;
    araddr_n      = m_araddr;
    rready_n      = m_rready;
    instr_valid_n = instr_valid;
    instruction_n = instruction;
    instr_pc_n    = instr_pc;
    instr_err_n   = instr_err;

    case (state)
      ST_START: begin
        if (redirect_valid) pc_n = target;
        arvalid_n = 1'b1;
        araddr_n  = pc_n;
        state_n   = ST_ADDR;
      end

      ST_ADDR: begin
        if (redirect_valid) begin
          pending_pc_n = target;
          kill_n       = 1'b1;
        end
        if (m_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (m_rvalid) begin
          rready_n = 1'b0;
          // A redirect arriving with the beat itself also kills it; the
          // newest target wins over any earlier pending one.
          if (kill || redirect_valid) begin
            pc_n      = redirect_valid ? target : pending_pc;
            kill_n    = 1'b0;
            arvalid_n = 1'b1;
            araddr_n  = pc_n;
            state_n   = ST_ADDR;
          end else begin
            instruction_n = m_rdata;
            instr_pc_n    = pc;
            instr_err_n   = (m_rresp != 2'b00);
            instr_valid_n = 1'b1;
            state_n       = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pending_pc_n = target;
          kill_n       = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          instr_valid_n = 1'b0;
          pc_n          = target;
          arvalid_n     = 1'b1;
          araddr_n      = target;
          state_n       = ST_ADDR;
        end else if (instr_ready) begin
          instr_valid_n = 1'b0;
          pc_n          = pc + 32'd4;
          arvalid_n     = 1'b1;
          araddr_n      = pc_n;
          state_n       = ST_ADDR;
        end
      end

      default: state_n = ST_START;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage_axi.sv
// Directed bench for fetch_stage_axi: the initial block plays both the AXI
// slave and the decode stage cycle by cycle, with hand-computed expectations.
module tb_fetch_stage_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cycle  = 0;
  int unsigned last_valid_cycle = 0;
  int unsigned prev_valid_cycle = 0;

  fetch_stage_axi #(
    .RESET_PC  (32'h0000_0000),
    .ARPROT_VAL(3'b100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .instr_err     (instr_err),
    .m_araddr      (m_araddr),
    .m_arprot      (m_arprot),
    .m_arvalid     (m_arvalid),
    .m_arready     (m_arready),
    .m_rdata       (m_rdata),
    .m_rresp       (m_rresp),
    .m_rvalid      (m_rvalid),
    .m_rready      (m_rready)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch from ADDR: hold arready low for ar_delay cycles, handshake,
  // return addr^A5A5_0000 with the given rresp, and end sampling in HOLD.
  task automatic fetch(input logic [31:0] addr, input int unsigned ar_delay,
                       input logic [1:0] resp);
    logic [31:0] word;
    word = addr ^ 32'hA5A5_0000;
    for (int unsigned i = 0; i < ar_delay; i++) begin
      chk("arvalid_wait", {31'd0, m_arvalid}, 32'd1);
      chk("araddr_wait", m_araddr, addr);
      step();
    end
    chk("arvalid", {31'd0, m_arvalid}, 32'd1);
    chk("araddr", m_araddr, addr);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("arvalid_after_hs", {31'd0, m_arvalid}, 32'd0);
    chk("rready", {31'd0, m_rready}, 32'd1);
    chk("valid_n_plus_1", {31'd0, instr_valid}, 32'd0);
    m_rvalid = 1'b1;
    m_rdata  = word;
    m_rresp  = resp;
    step();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_rresp  = 2'b00;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instruction", instruction, word);
    chk("instr_pc", instr_pc, addr);
    chk("instr_err", {31'd0, instr_err}, {31'd0, (resp != 2'b00)});
    chk("rready_after", {31'd0, m_rready}, 32'd0);
    prev_valid_cycle = last_valid_cycle;
    last_valid_cycle = cycle;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    m_arready      = 1'b0;
    m_rdata        = '0;
    m_rresp        = 2'b00;
    m_rvalid       = 1'b0;

    step();
    step();
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_err", {31'd0, instr_err}, 32'd0);
    chk("rst_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, m_rready}, 32'd0);
    chk("rst_araddr", m_araddr, 32'd0);
    chk("arprot", {29'd0, m_arprot}, 32'd4);

    rst = 1'b0;
    chk("start_arvalid", {31'd0, m_arvalid}, 32'd0);
    step();

    // Test 1: zero-wait slave, decode always ready -> 1 instr / 3 cycles.
    fetch(32'h0, 0, 2'b00);
    step();
    fetch(32'h4, 0, 2'b00);
    chk("throughput_4", last_valid_cycle - prev_valid_cycle, 32'd3);
    step();
    fetch(32'h8, 0, 2'b00);
    chk("throughput_8", last_valid_cycle - prev_valid_cycle, 32'd3);
    step();

    // Test 2: arready held low for 5 cycles.
    fetch(32'hC, 5, 2'b00);
    step();

    // Test 5: error response at 0x10, PC still advances.
    fetch(32'h10, 0, 2'b10);
    step();
    chk("after_err_araddr", m_araddr, 32'h14);

    // Test 3: decode stalls for 4 cycles in HOLD.
    instr_ready = 1'b0;
    fetch(32'h14, 0, 2'b00);
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instruction", instruction, 32'hA5A5_0014);
      chk("stall_instr_pc", instr_pc, 32'h14);
      chk("stall_no_ar", {31'd0, m_arvalid}, 32'd0);
    end
    instr_ready = 1'b1;
    step();
    chk("post_stall_arvalid", {31'd0, m_arvalid}, 32'd1);
    chk("post_stall_araddr", m_araddr, 32'h18);
    chk("post_stall_valid", {31'd0, instr_valid}, 32'd0);

    // Test 4: redirect to 0x103 while the read of 0x18 is in DATA.
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("redir_in_data", {31'd0, m_rready}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    chk("redir_still_data", {31'd0, m_rready}, 32'd1);
    m_rvalid = 1'b1;
    m_rdata  = 32'hA5A5_0018;
    step();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    chk("killed_no_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h100, 0, 2'b00);

    // Redirect in HOLD wins over a simultaneous instr_ready.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h200, 0, 2'b00);
    step();

    // Test 6: asynchronous reset while in DATA.
    chk("pre_rst_araddr", m_araddr, 32'h204);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    chk("pre_rst_rready", {31'd0, m_rready}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_arvalid", {31'd0, m_arvalid}, 32'd0);
    chk("async_rready", {31'd0, m_rready}, 32'd0);
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_araddr", m_araddr, 32'd0);
    step();
    rst = 1'b0;
    chk("restart_start", {31'd0, m_arvalid}, 32'd0);
    step();
    fetch(32'h0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
